image_scale_ctrl: RTL and testbench

//  Parametrised framebuffer controller. It copies a SRC_W x SRC_H source image from ROM into the

---
 rtl/scale_pkg.sv | 41 ++++
 rtl/raster_counter.sv | 53 +++++
 rtl/image_scale_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_image_scale_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scale_pkg.sv
// Shared encodings and dimension helpers for the image scaler.
package scale_pkg;

    localparam int unsigned DIM_W   = 11;
    localparam int unsigned DRAIN_W = 3;

    localparam logic [1:0] MODE_COPY = 2'b00;
    localparam logic [1:0] MODE_UP2  = 2'b01;
    localparam logic [1:0] MODE_DN2  = 2'b10;
    localparam logic [1:0] MODE_UP4  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    // Scaled size of one image dimension.
    function automatic logic [DIM_W-1:0] dst_dim(input logic [DIM_W-1:0] src,
                                                 input logic [1:0]       mode);
        case (mode)
            MODE_UP2: dst_dim = src << 1;
            MODE_DN2: dst_dim = src >> 1;
            MODE_UP4: dst_dim = src << 2;
            default:  dst_dim = src;
        endcase
    endfunction

    // Nearest-neighbour source coordinate for a destination coordinate.
    function automatic logic [DIM_W-1:0] src_coord(input logic [DIM_W-1:0] d,
                                                   input logic [1:0]       mode);
        case (mode)
            MODE_UP2: src_coord = d >> 1;
            MODE_DN2: src_coord = d << 1;
            MODE_UP4: src_coord = d >> 2;
            default:  src_coord = d;
        endcase
    endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster-order x/y counter: x wraps at width, y advances on each x wrap.
module raster_counter
    import scale_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [DIM_W-1:0] width,
    input  logic [DIM_W-1:0] height,
    output logic [DIM_W-1:0] x,
    output logic [DIM_W-1:0] y,
    output logic             last
);

    logic [DIM_W-1:0] x_q, x_d;
    logic [DIM_W-1:0] y_q, y_d;
    logic             x_end, y_end;

    assign x_end = (x_q == width - DIM_W'(1));
    assign y_end = (y_q == height - DIM_W'(1));

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clear) begin
            x_d = '0;
            y_d = '0;
        end else if (enable) begin
            if (x_end) begin
                x_d = '0;
                y_d = y_end ? '0 : y_q + DIM_W'(1);
            end else begin
                x_d = x_q + DIM_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x    = x_q;
    assign y    = y_q;
    assign last = x_end && y_end;

endmodule

// File: rtl/image_scale_ctrl.sv
// Framebuffer controller: nearest-neighbour ROM->RAM scale passes and
// centred VGA read mapping while idle.
module image_scale_ctrl
    import scale_pkg::*;
#(
    parameter int unsigned SRC_W   = 160,
    parameter int unsigned SRC_H   = 120,
    parameter int unsigned DISP_W  = 640,
    parameter int unsigned DISP_H  = 480,
    parameter int unsigned PIX_W   = 8,
    parameter int unsigned ROM_AW  = 17,
    parameter int unsigned RAM_AW  = 19,
    parameter int unsigned ROM_LAT = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [9:0]        disp_x,
    input  logic [9:0]        disp_y,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [PIX_W-1:0]  rom_q,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [PIX_W-1:0]  ram_wdata,
    output logic              ram_wren,
    output logic              disp_valid,
    output logic [10:0]       out_w,
    output logic [10:0]       out_h,
    output logic              busy,
    output logic              done
);

    localparam int unsigned TAIL = ROM_LAT - 1;

    state_e              state_q, state_d;
    logic                init_pend_q, init_pend_d;
    logic [1:0]          cur_mode_q, cur_mode_d;
    logic [DIM_W-1:0]    out_w_q, out_w_d;
    logic [DIM_W-1:0]    out_h_q, out_h_d;
    logic [DRAIN_W-1:0]  drain_cnt_q, drain_cnt_d;
    logic [ROM_LAT-1:0]  dl_vld_q, dl_vld_d;
    logic [RAM_AW-1:0]   dl_addr_q [ROM_LAT];
    logic [RAM_AW-1:0]   dl_addr_d [ROM_LAT];
    logic [RAM_AW-1:0]   ram_addr_q, ram_addr_d;
    logic [PIX_W-1:0]    ram_wdata_q, ram_wdata_d;
    logic                ram_wren_q, ram_wren_d;
    logic                disp_valid_q, disp_valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                go;
    logic [1:0]          mode_sel;
    logic [DIM_W-1:0]    dx, dy, sx, sy;
    logic                scan_last;
    logic [RAM_AW-1:0]   src_lin, dst_lin;
    logic [DIM_W-1:0]    off_x, off_y, px, py, rel_x, rel_y;
    logic                in_img;
    logic [RAM_AW-1:0]   disp_addr;

    // The init copy wins over a user start; start is ignored while done is high.
    assign go       = (state_q == S_IDLE) && (init_pend_q || (start && !done_q));
    assign mode_sel = init_pend_q ? MODE_COPY : mode;

    raster_counter u_dst_scan (
        .clock  (clock),
        .reset  (reset),
        .clear  (go),
        .enable (state_q == S_FILL),
        .width  (out_w_q),
        .height (out_h_q),
        .x      (dx),
        .y      (dy),
        .last   (scan_last)
    );

    // ROM address follows the scan counter directly so data returns ROM_LAT later.
    always_comb begin
        sx      = src_coord(dx, cur_mode_q);
        sy      = src_coord(dy, cur_mode_q);
        src_lin = RAM_AW'(sy) * RAM_AW'(SRC_W) + RAM_AW'(sx);
        dst_lin = RAM_AW'(dy) * RAM_AW'(out_w_q) + RAM_AW'(dx);
    end

    assign rom_addr = (state_q == S_FILL) ? ROM_AW'(src_lin) : '0;

    // Centred display window for the current image.
    always_comb begin
        off_x     = (DIM_W'(DISP_W) - out_w_q) >> 1;
        off_y     = (DIM_W'(DISP_H) - out_h_q) >> 1;
        px        = DIM_W'(disp_x);
        py        = DIM_W'(disp_y);
        rel_x     = px - off_x;
        rel_y     = py - off_y;
        in_img    = (px >= off_x) && (px < off_x + out_w_q) &&
                    (py >= off_y) && (py < off_y + out_h_q);
        disp_addr = RAM_AW'(rel_y) * RAM_AW'(out_w_q) + RAM_AW'(rel_x);
    end

    // Destination address/valid delay line matching the ROM latency.
    always_comb begin
        dl_vld_d[0]  = (state_q == S_FILL);
        dl_addr_d[0] = dst_lin;
        for (int i = 1; i < ROM_LAT; i++) begin
            dl_vld_d[i]  = dl_vld_q[i-1];
            dl_addr_d[i] = dl_addr_q[i-1];
        end
    end

    always_comb begin
        state_d     = state_q;
        init_pend_d = init_pend_q;
        cur_mode_d  = cur_mode_q;
        out_w_d     = out_w_q;
        out_h_d     = out_h_q;
        drain_cnt_d = drain_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    cur_mode_d  = mode_sel;
                    init_pend_d = 1'b0;
                    out_w_d     = dst_dim(DIM_W'(SRC_W), mode_sel);
                    out_h_d     = dst_dim(DIM_W'(SRC_H), mode_sel);
                    state_d     = S_FILL;
                end
            end
            S_FILL: begin
                if (scan_last) begin
                    drain_cnt_d = '0;
                    state_d     = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_cnt_q == DRAIN_W'(ROM_LAT - 1)) begin
                    state_d = S_DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_q == S_DONE);

        // RAM port: display reads when idle, delayed writes otherwise.
        if ((state_q == S_IDLE) && !go) begin
            ram_wren_d   = 1'b0;
            ram_wdata_d  = '0;
            disp_valid_d = in_img;
            ram_addr_d   = in_img ? disp_addr : '0;
        end else begin
            ram_wren_d   = dl_vld_q[TAIL];
            ram_wdata_d  = dl_vld_q[TAIL] ? rom_q : '0;
            disp_valid_d = 1'b0;
            ram_addr_d   = dl_vld_q[TAIL] ? dl_addr_q[TAIL] : '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            init_pend_q  <= 1'b1;
            cur_mode_q   <= MODE_COPY;
            out_w_q      <= DIM_W'(SRC_W);
            out_h_q      <= DIM_W'(SRC_H);
            drain_cnt_q  <= '0;
            dl_vld_q     <= '0;
            for (int i = 0; i < ROM_LAT; i++) begin
                dl_addr_q[i] <= '0;
            end
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            ram_wren_q   <= 1'b0;
            disp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            init_pend_q  <= init_pend_d;
            cur_mode_q   <= cur_mode_d;
            out_w_q      <= out_w_d;
            out_h_q      <= out_h_d;
            drain_cnt_q  <= drain_cnt_d;
            dl_vld_q     <= dl_vld_d;
            for (int i = 0; i < ROM_LAT; i++) begin
                dl_addr_q[i] <= dl_addr_d[i];
            end
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            ram_wren_q   <= ram_wren_d;
            disp_valid_q <= disp_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;
    assign ram_wren   = ram_wren_q;
    assign disp_valid = disp_valid_q;
    assign out_w      = out_w_q;
    assign out_h      = out_h_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_image_scale_ctrl.sv
// Scoreboard bench for image_scale_ctrl: random ROM image, reference scaler model,
// write/done/display checking in a separate monitor.
module tb_image_scale_ctrl;

    localparam int SRC_W   = 16;
    localparam int SRC_H   = 12;
    localparam int DISP_W  = 64;
    localparam int DISP_H  = 48;
    localparam int PIX_W   = 8;
    localparam int ROM_AW  = 17;
    localparam int RAM_AW  = 19;
    localparam int ROM_LAT = 2;
    localparam int SRC_N   = SRC_W * SRC_H;
    localparam int RAM_N   = DISP_W * DISP_H;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [1:0]        mode = 2'b00;
    logic [9:0]        disp_x = '0;
    logic [9:0]        disp_y = '0;
    logic [ROM_AW-1:0] rom_addr;
    logic [PIX_W-1:0]  rom_q;
    logic [RAM_AW-1:0] ram_addr;
    logic [PIX_W-1:0]  ram_wdata;
    logic              ram_wren;
    logic              disp_valid;
    logic [10:0]       out_w;
    logic [10:0]       out_h;
    logic              busy;
    logic              done;

    image_scale_ctrl #(
        .SRC_W(SRC_W), .SRC_H(SRC_H), .DISP_W(DISP_W), .DISP_H(DISP_H),
        .PIX_W(PIX_W), .ROM_AW(ROM_AW), .RAM_AW(RAM_AW), .ROM_LAT(ROM_LAT)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .mode(mode),
        .disp_x(disp_x), .disp_y(disp_y), .rom_addr(rom_addr), .rom_q(rom_q),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wren(ram_wren),
        .disp_valid(disp_valid), .out_w(out_w), .out_h(out_h),
        .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    typedef struct { int addr; int data; } wr_t;
    typedef struct { int addr; int vld; }  dq_t;

    wr_t  exp_wr[$];
    int   exp_done[$];
    dq_t  exp_disp[$];

    logic [PIX_W-1:0] rom_mem [SRC_N];
    logic [PIX_W-1:0] ram_mem [RAM_N];
    logic [PIX_W-1:0] rom_pipe [ROM_LAT];

    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   cur_ow = SRC_W;
    int   cur_oh = SRC_H;
    logic disp_issue = 1'b0;
    logic disp_chk = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;
    always @(posedge clock) disp_chk <= disp_issue;

    // ROM with ROM_LAT cycles of read latency
    always @(posedge clock) begin
        for (int i = ROM_LAT - 1; i > 0; i--) rom_pipe[i] <= rom_pipe[i-1];
        rom_pipe[0] <= (int'(rom_addr) < SRC_N) ? rom_mem[int'(rom_addr)] : '0;
    end
    assign rom_q = rom_pipe[ROM_LAT-1];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int dim(input int s, input int m);
        case (m)
            1: return 2 * s;
            2: return s / 2;
            3: return 4 * s;
            default: return s;
        endcase
    endfunction

    function automatic int src_of(input int d, input int m);
        case (m)
            1: return d / 2;
            2: return d * 2;
            3: return d / 4;
            default: return d;
        endcase
    endfunction

    // Reference scaler: every destination pixel in raster order.
    task automatic push_pass(input int m);
        wr_t e;
        cur_ow = dim(SRC_W, m);
        cur_oh = dim(SRC_H, m);
        for (int y = 0; y < cur_oh; y++) begin
            for (int x = 0; x < cur_ow; x++) begin
                e.addr = y * cur_ow + x;
                e.data = int'(rom_mem[src_of(y, m) * SRC_W + src_of(x, m)]);
                exp_wr.push_back(e);
            end
        end
    endtask

    // Monitor: compares whatever the DUT presents against the queues.
    always @(negedge clock) begin
        if (reset) begin
            if (ram_wren) begin
                if (exp_wr.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL wr_unexpected: got write addr %0d data %0d, expected none",
                             ram_addr, ram_wdata);
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    chk("wr_addr", int'(ram_addr), e.addr);
                    chk("wr_data", int'(ram_wdata), e.data);
                end
                if (int'(ram_addr) < RAM_N) ram_mem[int'(ram_addr)] = ram_wdata;
            end
            if (done) begin
                if (exp_done.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL done_unexpected: got done at cycle %0d, expected none", cyc);
                end else begin
                    chk("done_cycle", cyc, exp_done.pop_front());
                    chk("done_writes_left", exp_wr.size(), 0);
                end
            end
            if (disp_chk && exp_disp.size() != 0) begin
                dq_t d;
                d = exp_disp.pop_front();
                chk("disp_addr", int'(ram_addr), d.addr);
                chk("disp_valid", int'(disp_valid), d.vld);
            end
        end
    end

    task automatic release_reset();
        reset = 1'b1;
        push_pass(0);
        exp_done.push_back(cyc + 1 + cur_ow * cur_oh + ROM_LAT + 1);
    endtask

    task automatic start_pass(input int m);
        @(posedge clock); #1;
        start = 1'b1;
        mode  = 2'(m);
        push_pass(m);
        @(posedge clock); #1;
        start = 1'b0;
        mode  = 2'($urandom_range(0, 3));
        exp_done.push_back(cyc + cur_ow * cur_oh + ROM_LAT + 1);
        chk("out_w", int'(out_w), cur_ow);
        chk("out_h", int'(out_h), cur_oh);
        chk("busy_on_start", int'(busy), 1);
    endtask

    // Waits for done, then pulses start in the done cycle, which must be ignored.
    task automatic finish_pass();
        bit seen = 1'b0;
        for (int k = 0; k < cur_ow * cur_oh + 50 && !seen; k++) begin
            @(negedge clock);
            if (done === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            n_cmp++;
            n_fail++;
            $display("FAIL done_timeout: got no done, expected one within %0d cycles",
                     cur_ow * cur_oh + 50);
        end
        start = 1'b1;
        mode  = 2'($urandom_range(0, 3));
        @(posedge clock); #1;
        start = 1'b0;
        chk("start_ignored_at_done", int'(busy), 0);
    endtask

    task automatic disp_probe(input int x, input int y);
        dq_t d;
        int  ox, oy;
        @(posedge clock); #1;
        disp_x     = 10'(x);
        disp_y     = 10'(y);
        disp_issue = 1'b1;
        ox = (DISP_W - cur_ow) / 2;
        oy = (DISP_H - cur_oh) / 2;
        if (x >= ox && x < ox + cur_ow && y >= oy && y < oy + cur_oh) begin
            d.addr = (y - oy) * cur_ow + (x - ox);
            d.vld  = 1;
        end else begin
            d.addr = 0;
            d.vld  = 0;
        end
        exp_disp.push_back(d);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1);
    end

    initial begin
        int ox, oy;
        for (int i = 0; i < SRC_N; i++) rom_mem[i] = PIX_W'($urandom);
        for (int i = 0; i < RAM_N; i++) ram_mem[i] = '0;

        repeat (3) @(posedge clock);
        #1;
        chk("rst_rom_addr", int'(rom_addr), 0);
        chk("rst_ram_addr", int'(ram_addr), 0);
        chk("rst_ram_wdata", int'(ram_wdata), 0);
        chk("rst_ram_wren", int'(ram_wren), 0);
        chk("rst_disp_valid", int'(disp_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_out_w", int'(out_w), SRC_W);
        chk("rst_out_h", int'(out_h), SRC_H);

        release_reset();
        finish_pass();
        chk("init_out_w", int'(out_w), SRC_W);

        start_pass(1);
        finish_pass();
        chk("up2_ram0", int'(ram_mem[0]), int'(rom_mem[0]));
        chk("up2_ram1", int'(ram_mem[1]), int'(rom_mem[0]));
        chk("up2_ram_w", int'(ram_mem[cur_ow]), int'(rom_mem[0]));
        chk("up2_ram_w1", int'(ram_mem[cur_ow + 1]), int'(rom_mem[0]));
        chk("up2_ram2", int'(ram_mem[2]), int'(rom_mem[1]));

        ox = (DISP_W - cur_ow) / 2;
        oy = (DISP_H - cur_oh) / 2;
        disp_probe(ox, oy);
        disp_probe(ox - 1, oy);
        disp_probe(ox + cur_ow - 1, oy + cur_oh - 1);
        disp_probe(ox + cur_ow, oy);
        disp_probe(ox, oy + cur_oh);
        disp_probe(ox, oy - 1);
        for (int i = 0; i < 24; i++) disp_probe($urandom_range(0, DISP_W - 1), $urandom_range(0, DISP_H - 1));
        @(posedge clock); #1;
        disp_issue = 1'b0;
        @(posedge clock); #1;
        chk("disp_queue_empty", exp_disp.size(), 0);

        start_pass(3);
        finish_pass();
        chk("up4_ram_w1", int'(ram_mem[cur_ow + 1]), int'(rom_mem[0]));
        chk("up4_ram_last", int'(ram_mem[cur_ow * cur_oh - 1]), int'(rom_mem[SRC_N - 1]));

        start_pass(2);
        repeat (7) @(posedge clock);
        #1;
        start = 1'b1;
        mode  = 2'd3;
        @(posedge clock); #1;
        start = 1'b0;
        chk("out_w_hold_midpass", int'(out_w), cur_ow);
        finish_pass();
        chk("dn2_ram1", int'(ram_mem[1]), int'(rom_mem[2]));
        chk("dn2_ram_w", int'(ram_mem[cur_ow]), int'(rom_mem[2 * SRC_W]));

        start_pass(0);
        finish_pass();
        repeat (2) begin
            start_pass($urandom_range(0, 3));
            finish_pass();
        end

        // Abort a pass with reset, then expect the init copy again.
        start_pass(3);
        repeat (100) @(posedge clock);
        #1;
        reset = 1'b0;
        exp_wr.delete();
        exp_done.delete();
        @(posedge clock); #1;
        chk("abort_ram_wren", int'(ram_wren), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_rom_addr", int'(rom_addr), 0);
        chk("abort_out_w", int'(out_w), SRC_W);
        release_reset();
        finish_pass();
        chk("post_abort_out_w", int'(out_w), SRC_W);

        chk("exp_wr_empty", exp_wr.size(), 0);
        chk("exp_done_empty", exp_done.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
